seq_divider_ctrl: RTL and testbench

Multi-cycle unsigned restoring divider built around a single shared (WIDTH+1)-bit subtract unit, realised as A + ~B + 1. An FSM and an iteration counter sequence that unit.
- One trial subtraction per clock.
- start/busy/done handshake to the surrounding logic.
- Produces quotient, remainder and a divide-by-zero flag.

---
 rtl/seq_divider_ctrl.sv | 138 +++++++++++++
 tb/tb_seq_divider_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_ctrl.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per clock through a
// single shared (WIDTH+1)-bit subtract unit, sequenced by an IDLE/CALC/FINISH FSM.
module seq_divider_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned RW    = WIDTH + 1;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [RW-1:0]    r_q, r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  // Shared subtract unit: trial = Rs + ~{0,D} + 1, carry-out set means no borrow.
  logic [RW-1:0] rs_c;
  logic [RW-1:0] nd_c;
  logic [RW:0]   sum_c;
  logic          carry_c;
  logic          last_iter_c;

  assign rs_c        = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign nd_c        = ~{1'b0, d_q};
  assign sum_c       = {1'b0, rs_c} + {1'b0, nd_c} + (RW + 1)'(1);
  assign carry_c     = sum_c[RW];
  assign last_iter_c = (cnt_q == CNT_W'(WIDTH - 1));

  // R stays below D, so its top bit only matters inside the subtract unit width.
  logic unused_c;
  assign unused_c = r_q[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          q_d     = dividend;
          d_d     = divisor;
          r_d     = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = (divisor == '0) ? FINISH : CALC;
        end
      end
      CALC: begin
        if (carry_c) begin
          r_d = sum_c[RW-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = rs_c;
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter_c) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        // Divide-by-zero never iterates, so Q still holds the captured dividend.
        if (d_q == '0) begin
          quot_d = '1;
          rem_d  = q_q;
          dbz_d  = 1'b1;
        end else begin
          quot_d = q_q;
          rem_d  = r_q[WIDTH-1:0];
          dbz_d  = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_ctrl.sv
// Self-checking bench for seq_divider_ctrl: directed divisions compared every cycle
// against an arithmetic reference model, plus hand-computed results and latencies.
module tb_seq_divider_ctrl;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  always #5 clk = ~clk;

  seq_divider_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a countdown of edges until the result, results from / and %.
  logic         m_busy, m_done, m_dbz;
  logic [W-1:0] m_q, m_r, m_a, m_b;
  int           m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
      m_q <= '0; m_r <= '0; m_a <= '0; m_b <= '0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          if (m_b == '0) begin
            m_q <= '1; m_r <= m_a; m_dbz <= 1'b1;
          end else begin
            m_q <= W'(m_a / m_b); m_r <= W'(m_a % m_b); m_dbz <= 1'b0;
          end
        end else begin
          m_left <= m_left - 1;
        end
      end else if (start) begin
        m_a    <= dividend;
        m_b    <= divisor;
        m_busy <= 1'b1;
        m_left <= (divisor == '0) ? 1 : int'(W) + 1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en && rst_n) begin
      check("busy",        int'(busy),        int'(m_busy));
      check("done",        int'(done),        int'(m_done));
      check("quotient",    int'(quotient),    int'(m_q));
      check("remainder",   int'(remainder),   int'(m_r));
      check("div_by_zero", int'(div_by_zero), int'(m_dbz));
    end
  end

  task automatic start_req(input logic [W-1:0] a, input logic [W-1:0] b, output int e0);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    #2;
    e0 = cyc;
  endtask

  task automatic wait_done(input string name, output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #2;
      if (done) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic check_res(input string name, input int q, input int r, input int z);
    check({name, "_q"},   int'(quotient),    q);
    check({name, "_r"},   int'(remainder),   r);
    check({name, "_dbz"}, int'(div_by_zero), z);
  endtask

  task automatic run(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                     input int q, input int r, input int z, input int lat);
    int e0, at;
    start_req(a, b, e0);
    @(negedge clk);
    start = 1'b0;
    wait_done(name, at);
    check({name, "_lat"}, at - e0, lat);
    check_res(name, q, r, z);
  endtask

  task automatic count_done(input string name, input int n);
    int nd = 0;
    repeat (n) begin
      @(posedge clk);
      #2;
      if (done) nd++;
    end
    check({name, "_extra_done"}, nd, 0);
  endtask

  initial begin
    int e0, d1, d2;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check_res("rst", 0, 0, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    run("t1_13_4", 4'd13, 4'd4, 3, 1, 0, 5);
    run("t2_15_1", 4'd15, 4'd1, 15, 0, 0, 5);
    run("t2_5_7",  4'd5,  4'd7, 0, 5, 0, 5);
    run("t2_0_3",  4'd0,  4'd3, 0, 0, 0, 5);
    run("t2_15_15", 4'd15, 4'd15, 1, 0, 0, 5);
    run("t3_9_0",  4'd9,  4'd0, 15, 9, 1, 1);
    run("t3_9_3",  4'd9,  4'd3, 3, 0, 0, 5);

    // Second request while busy, with the operand buses changing underneath.
    start_req(4'd12, 4'd5, e0);
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; dividend = 4'd7; divisor = 4'd7;
    @(negedge clk); dividend = 4'd1; divisor = 4'd0;
    @(negedge clk); start = 1'b0; dividend = 4'd3; divisor = 4'd2;
    wait_done("t4", d1);
    check("t4_lat", d1 - e0, 5);
    check_res("t4", 2, 2, 0);
    count_done("t4", 8);

    // Asynchronous reset mid-division.
    start_req(4'd14, 4'd3, e0);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_done", int'(done), 0);
    check_res("t5_rst", 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_done("t5", 8);
    run("t5_14_3", 4'd14, 4'd3, 4, 2, 0, 5);

    // start held high: back-to-back divisions.
    start_req(4'd11, 4'd2, e0);
    wait_done("t6a", d1);
    check("t6a_lat", d1 - e0, 5);
    check_res("t6a", 5, 1, 0);
    wait_done("t6b", d2);
    check("t6_period", d2 - d1, int'(W) + 2);
    check_res("t6b", 5, 1, 0);
    @(negedge clk); start = 1'b0;
    count_done("t6", 10);

    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
